// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator feed path.
package acc_pkg;
  localparam int ACC_DATA_W    = 8;
  localparam int ACC_FRAME_LEN = 500;
  localparam int ACC_DEPTH     = 16;

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} acc_feed_state_t;

  // Saturating increment for the 16-bit drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/acc_sync_fifo.sv
// Synchronous FIFO: packed storage, wrapping pointers, registered occupancy.
// Push/pop requests are qualified internally against full/empty.
module acc_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]                wptr, rptr;
  logic                         do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (!do_push && do_pop) level <= level - LW'(1);
    end
  end
endmodule

// File: rtl/acc_feed_fifo.sv
// Accumulator feed: buffers samples, frames them into FRAME_LEN blocks with a
// clear before and a done strobe on the last sample. Drop mode: ACC_FEED_DROP_EN.
module acc_feed_fifo
  import acc_pkg::*;
#(
  parameter int DATA_W    = ACC_DATA_W,
  parameter int DEPTH     = ACC_DEPTH,
  parameter int FRAME_LEN = ACC_FRAME_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic                    acc_stall,
  output logic [DATA_W-1:0]       acc_data,
  output logic                    acc_en,
  output logic                    acc_clr,
  output logic                    frame_done,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             drop_cnt
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  acc_feed_state_t  state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [DATA_W-1:0] head;
  logic             full, empty, push, pop;

  // No full bypass: a full FIFO refuses even if a pop happens this cycle.
  assign push = in_valid && !full;
  assign pop  = (state == RUN) && !empty && !acc_stall;

  acc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

`ifdef ACC_FEED_DROP_EN
  assign in_ready = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  drop_cnt <= '0;
    else if (in_valid && full) drop_cnt <= sat_inc16(drop_cnt);
  end
`else
  assign in_ready = !full;
  assign drop_cnt = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    acc_clr    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (!empty) state_nxt = CLR;
      CLR: begin
        acc_clr   = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (pop && cnt == LAST) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= '0;
    else if (state == CLR)  cnt <= '0;
    else if (pop)           cnt <= cnt + CW'(1);
  end

  // One-stage output register: acc_en is the pop delayed by a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_en   <= 1'b0;
      acc_data <= '0;
    end else begin
      acc_en <= pop;
      if (pop) acc_data <= head;
    end
  end
endmodule

// File: tb/tb_acc_feed_fifo.sv
// Scoreboard bench for acc_feed_fifo (DEPTH=8, FRAME_LEN=4).
module tb_acc_feed_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int FL    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          acc_stall = 1'b0;
  logic          in_ready, acc_en, acc_clr, frame_done;
  logic [DW-1:0] acc_data;
  logic [LW-1:0] level;
  logic [15:0]   drop_cnt;

  acc_feed_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .acc_stall(acc_stall), .acc_data(acc_data),
    .acc_en(acc_en), .acc_clr(acc_clr), .frame_done(frame_done),
    .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int idx = 0;
  bit clr_seen = 1'b0;
  int in_sum = 0, out_sum = 0, n_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: pops the scoreboard on every acc_en and checks framing.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      idx = 0;
      clr_seen = 1'b0;
    end else begin
      if (acc_clr) begin
        clr_seen = 1'b1;
        idx = 0;
      end
      if (acc_en) begin
        if (exp_q.size() == 0) fail_evt("acc_en_unexpected");
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("acc_data", 32'(acc_data), 32'(e));
          out_sum += int'(acc_data);
          n_out++;
        end
        if (idx == 0) chk("clr_before_frame", 32'(clr_seen), 32'd1);
        chk("frame_done", 32'(frame_done), 32'(idx == FL - 1));
        idx++;
        if (idx == FL) begin
          idx = 0;
          clr_seen = 1'b0;
        end
      end else if (frame_done) fail_evt("frame_done_without_acc_en");
    end
  end

  task automatic push_hs(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(d);
        in_sum += int'(d);
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) fail_evt("push_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500; t++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) fail_evt("drain_timeout");
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_acc_en", 32'(acc_en), 32'd0);
    chk("rst_acc_clr", 32'(acc_clr), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single frame 01..04 with first-sample latency checks
    in_valid = 1'b1; in_data = 8'h01; exp_q.push_back(8'h01);
    @(negedge clk); chk("t_clr_before", 32'(acc_clr), 32'd0);
    @(posedge clk); #1; in_data = 8'h02; exp_q.push_back(8'h02);
    @(negedge clk); chk("t_level1", 32'(level), 32'd1);
    chk("t_clr_n", 32'(acc_clr), 32'd0);
    @(posedge clk); #1; in_data = 8'h03; exp_q.push_back(8'h03);
    @(negedge clk); chk("t_clr_n1", 32'(acc_clr), 32'd1);
    @(posedge clk); #1; in_data = 8'h04; exp_q.push_back(8'h04);
    @(negedge clk); chk("t_en_n2", 32'(acc_en), 32'd0);
    chk("t_clr_n2", 32'(acc_clr), 32'd0);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk("t_en_n3", 32'(acc_en), 32'd1);
    wait_drain();

`ifndef ACC_FEED_DROP_EN
    // Full FIFO under stall: only DEPTH samples accepted
    acc_stall = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      in_data = 8'(8'h10 + k);
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'(k < DEPTH));
      if (k < DEPTH) exp_q.push_back(in_data);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_in_ready_hold", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    acc_stall = 1'b0;
    wait_drain();
`endif

    // Stall for 3 cycles mid-frame
    for (int k = 0; k < 4; k++) push_hs(8'(8'hA0 + k));
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (acc_en) break;
    end
    @(posedge clk); #1;
    acc_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_no_en", 32'(acc_en), 32'd0);
      chk("stall_level", 32'(level), 32'd2);
    end
    acc_stall = 1'b0;
    wait_drain();

    // Back-to-back frames with random data
    in_sum = 0; out_sum = 0; n_out = 0;
    for (int k = 0; k < 5 * FL; k++) push_hs(8'($urandom_range(0, 255)));
    wait_drain();
    chk("rand_sum", 32'(out_sum), 32'(in_sum));
    chk("rand_count", 32'(n_out), 32'(5 * FL));

    // Reset mid-stream with level=5
    acc_stall = 1'b1;
    for (int k = 0; k < 5; k++) push_hs(8'(8'h50 + k));
    @(negedge clk);
    chk("pre_rst_level", 32'(level), 32'd5);
    #1 rst = 1'b0;
    #1;
    chk("mrst_level", 32'(level), 32'd0);
    chk("mrst_acc_en", 32'(acc_en), 32'd0);
    chk("mrst_acc_clr", 32'(acc_clr), 32'd0);
    chk("mrst_frame_done", 32'(frame_done), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    acc_stall = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) push_hs(8'(8'hB0 + k));
    wait_drain();

`ifdef ACC_FEED_DROP_EN
    // Drop mode: pushes into a full FIFO are counted and discarded
    acc_stall = 1'b1;
    for (int k = 0; k < DEPTH; k++) push_hs(8'(8'hC0 + k));
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'hE0 + k);
      @(negedge clk);
      chk("drop_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drop_cnt", 32'(drop_cnt), 32'd3);
    chk("drop_level", 32'(level), 32'(DEPTH));
    @(posedge clk); #1;
    acc_stall = 1'b0;
    wait_drain();
`else
    chk("drop_cnt_tied", 32'(drop_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/acc_feed_fifo.md
# acc_feed_fifo

Upstream feed stage for the accumulator. It buffers 8-bit samples from a producer in a synchronous FIFO, frames them into fixed-length blocks of FRAME_LEN samples, and drives the accumulator's data/enable inputs. It pulses a clear before each frame and a done strobe on the frame's last sample, so the accumulator's sum is a per-frame total.

## Interface
- DATA_W, 8: sample width; matches the accumulator data_in.
- DEPTH, 16: FIFO depth in words; power of two, at least 2.
- FRAME_LEN, 500: samples per frame; at least 1.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  producer has a sample.
- in_data  in  DATA_W  producer sample.
- in_ready  out  1  FIFO can accept a sample.
- acc_stall  in  1  accumulator cannot take a sample this cycle.
- acc_data  out  DATA_W  sample to the accumulator.
- acc_en  out  1  acc_data is valid this cycle; high for exactly one cycle per sample.
- acc_clr  out  1  accumulator clear; one-cycle pulse before each frame.
- frame_done  out  1  one-cycle pulse coincident with the acc_en of the last sample in a frame.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  16  count of dropped samples (see Configuration).

## Operation
- Push: at the clock edge where in_valid && in_ready, the sample is written.
  - in_ready = (level != DEPTH), decoded from registered state.
  - There is no full-FIFO bypass: when full, in_ready stays 0 even if a pop occurs in the same cycle.
- Pop: occurs only in RUN, when level != 0 && !acc_stall.
  - At that edge, acc_data is loaded with the FIFO head and acc_en goes to 1 for the next cycle.
  - Otherwise acc_en returns to 0 and acc_data holds its value.
- Simultaneous push and pop when not full: both take effect and level is unchanged.
- State machine (acc_feed_state_t):
  - IDLE: go to CLR when level != 0.
  - CLR: lasts one cycle, with acc_clr = 1; the frame counter is set to 0; go to RUN.
  - RUN: each pop increments the counter. A pop with counter == FRAME_LEN-1 goes to DONE.
  - DONE: lasts one cycle, with frame_done = 1; go to IDLE.
- acc_clr and frame_done are Moore decodes of the registered state.
- Frame counter width is $clog2(FRAME_LEN+1). FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
- Reset (any time, including mid-frame): FIFO empty, pointers 0, state IDLE, counter 0, drop_cnt 0. All outputs are 0, except in_ready, which is 1.
  - A partial frame is discarded. The accumulator receives acc_clr again before the next frame.

## Timing
- First sample written at edge N into an empty FIFO, with the FSM in IDLE and no stall:
  - acc_clr is high in cycle N+1 (between edges N+1 and N+2).
  - RUN starts at edge N+2.
  - The first acc_en is high in cycle N+3.
- Sustained throughput is one sample per cycle in RUN, while the FIFO is non-empty and there is no stall.
- acc_stall is sampled at the pop edge. It does not retract an acc_en already asserted.
- Between frames there are two dead cycles (DONE, then IDLE) plus one CLR cycle.

## Configuration
- ACC_FEED_DROP_EN defined:
  - in_ready is tied to 1.
  - A push attempted while full is discarded, and drop_cnt increments (saturating at 16'hFFFF).
- ACC_FEED_DROP_EN undefined:
  - The FIFO applies backpressure through in_ready.
  - drop_cnt is tied to 0.

## Structure
- Package acc_pkg holds:
  - typedef enum acc_feed_state_t {IDLE, CLR, RUN, DONE};
  - default constants ACC_DATA_W = 8 and ACC_FRAME_LEN = 500.
- Sub-module acc_sync_fifo (parameters DATA_W and DEPTH) contains the storage, pointers, level, and full/empty. acc_feed_fifo contains the FSM, frame counter and output registers.

## Test plan
- Reset: assert rst=0 mid-stream with level=5 -> level=0, acc_en=0, acc_clr=0, frame_done=0, in_ready=1. After release, the next frame starts with acc_clr.
- Single frame, FRAME_LEN=4: push 8'h01, 8'h02, 8'h03, 8'h04 back-to-back -> one acc_clr pulse, then acc_en for 4 consecutive cycles with data 01..04. frame_done coincides with data 04.
- Full FIFO, DEPTH=4, acc_stall=1: push 6 samples -> level=4, in_ready=0, samples 5 and 6 not accepted. Release the stall -> 4 samples out in order.
- Stall mid-frame: assert acc_stall for 3 cycles during RUN -> no acc_en in the following cycles, no lost or duplicated sample, and the frame counter is unchanged.
- Frames back-to-back, FRAME_LEN=500, random data -> exactly 500 acc_en per frame. The sum of acc_data equals the sum of pushed data, and acc_clr precedes each frame.
- With ACC_FEED_DROP_EN: full FIFO, push 3 more samples -> drop_cnt=3, in_ready=1, and FIFO contents unchanged.
